// File: rtl/rx_iq_scheduler_pkg.sv
// rtl/rx_iq_scheduler_pkg.sv - shared types for the RX IQ pairing scheduler
package rx_iq_scheduler_pkg;

   localparam int IQ_SAMPLE_W = 24;
   localparam int IQ_FRAME_W  = 4 * IQ_SAMPLE_W;

   typedef logic signed [IQ_SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t i;
      sample_t q;
   } iq_pair_t;

   // RX1 sits in the upper half so a flat frame reads RX1_I, RX1_Q, RX2_I, RX2_Q
   typedef struct packed {
      iq_pair_t rx1;
      iq_pair_t rx2;
   } iq_frame_t;

   typedef enum logic [1:0] {
      ST_COLLECT  = 2'd0,
      ST_HAVE_RX1 = 2'd1,
      ST_HAVE_RX2 = 2'd2
   } pair_state_t;

   function automatic iq_frame_t make_frame(input iq_pair_t rx1, input iq_pair_t rx2);
      iq_frame_t f;
      f.rx1 = rx1;
      f.rx2 = rx2;
      return f;
   endfunction

endpackage

// File: rtl/rx_iq_scheduler_if.sv
// rtl/rx_iq_scheduler_if.sv - DDC sample inputs and STM32-side IQ read port
interface rx_iq_scheduler_if
   import rx_iq_scheduler_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) ();

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic             rx2_en;
   logic             rx1_valid;
   sample_t          RX1_I;
   sample_t          RX1_Q;
   logic             rx2_valid;
   sample_t          RX2_I;
   sample_t          RX2_Q;
   logic             read_req;
   logic             overrun_clr;

   sample_t          OUT_RX1_I;
   sample_t          OUT_RX1_Q;
   sample_t          OUT_RX2_I;
   sample_t          OUT_RX2_Q;
   logic             in_empty;
   logic             iq_overrun;
   logic             sync_err;
   logic [LVL_W-1:0] fill_level;

   modport master (
      output rx2_en, rx1_valid, RX1_I, RX1_Q, rx2_valid, RX2_I, RX2_Q, read_req, overrun_clr,
      input  OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q, in_empty, iq_overrun, sync_err,
             fill_level
   );

   modport slave (
      input  rx2_en, rx1_valid, RX1_I, RX1_Q, rx2_valid, RX2_I, RX2_Q, read_req, overrun_clr,
      output OUT_RX1_I, OUT_RX1_Q, OUT_RX2_I, OUT_RX2_Q, in_empty, iq_overrun, sync_err,
             fill_level
   );

endinterface

// File: rtl/rx_iq_scheduler_iq_frame_fifo.sv
// rtl/rx_iq_scheduler_iq_frame_fifo.sv - synchronous frame FIFO with wrap-bit pointers
module iq_frame_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 96
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A pop frees the head slot this edge, so a full FIFO can still take a push
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_in) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_i;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/rx_iq_scheduler.sv
// rtl/rx_iq_scheduler.sv - pairs RX1/RX2 DDC samples into frames and queues them for the STM32
module rx_iq_scheduler
   import rx_iq_scheduler_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk_in,
   input  logic              reset_in,
   rx_iq_scheduler_if.slave  bus
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   pair_state_t      state_q;
   iq_pair_t         h1_q;
   iq_pair_t         h2_q;
   logic             rx2_en_q;
   logic             en_change;

   iq_pair_t         rx1_in;
   iq_pair_t         rx2_in;
   logic             done_d;
   logic             sync_set_d;
   iq_frame_t        frame_d;

   logic             wr_valid_q;
   iq_frame_t        wr_frame_q;

   logic [IQ_FRAME_W-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] fifo_level;
   logic             pop;
   logic             overrun_set;

   logic             iq_overrun_q;
   logic             sync_err_q;
   iq_frame_t        out_q;

   assign rx1_in    = {bus.RX1_I, bus.RX1_Q};
   assign rx2_in    = {bus.RX2_I, bus.RX2_Q};
   assign en_change = (bus.rx2_en != rx2_en_q);

   // Frame completion and pairing errors; a mode change swallows the cycle's strobes
   always_comb begin
      done_d     = 1'b0;
      sync_set_d = 1'b0;
      frame_d    = '0;
      if (!en_change) begin
         if (!bus.rx2_en) begin
            if (bus.rx1_valid) begin
               done_d  = 1'b1;
               frame_d = make_frame(rx1_in, '0);
            end
         end else begin
            case (state_q)
               ST_COLLECT: begin
                  if (bus.rx1_valid && bus.rx2_valid) begin
                     done_d  = 1'b1;
                     frame_d = make_frame(rx1_in, rx2_in);
                  end
               end
               ST_HAVE_RX1: begin
                  if (bus.rx2_valid) begin
                     done_d  = 1'b1;
                     frame_d = make_frame(h1_q, rx2_in);
                  end
                  sync_set_d = bus.rx1_valid;
               end
               ST_HAVE_RX2: begin
                  if (bus.rx1_valid) begin
                     done_d  = 1'b1;
                     frame_d = make_frame(rx1_in, h2_q);
                  end
                  sync_set_d = bus.rx2_valid;
               end
               default: begin
                  done_d = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q  <= ST_COLLECT;
         h1_q     <= '0;
         h2_q     <= '0;
         rx2_en_q <= bus.rx2_en;
      end else begin
         rx2_en_q <= bus.rx2_en;
         if (en_change) begin
            state_q <= ST_COLLECT;
            h1_q    <= '0;
            h2_q    <= '0;
         end else if (!bus.rx2_en) begin
            state_q <= ST_COLLECT;
         end else begin
            case (state_q)
               ST_COLLECT: begin
                  if (bus.rx1_valid && !bus.rx2_valid) begin
                     h1_q    <= rx1_in;
                     state_q <= ST_HAVE_RX1;
                  end else if (bus.rx2_valid && !bus.rx1_valid) begin
                     h2_q    <= rx2_in;
                     state_q <= ST_HAVE_RX2;
                  end
               end
               ST_HAVE_RX1: begin
                  if (bus.rx1_valid) begin
                     h1_q <= rx1_in;
                  end else if (bus.rx2_valid) begin
                     state_q <= ST_COLLECT;
                  end
               end
               ST_HAVE_RX2: begin
                  if (bus.rx2_valid) begin
                     h2_q <= rx2_in;
                  end else if (bus.rx1_valid) begin
                     state_q <= ST_COLLECT;
                  end
               end
               default: begin
                  state_q <= ST_COLLECT;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_valid_q <= 1'b0;
         wr_frame_q <= '0;
      end else begin
         wr_valid_q <= done_d;
         wr_frame_q <= frame_d;
      end
   end

   iq_frame_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (IQ_FRAME_W)
   ) u_fifo (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .push_i   (wr_valid_q),
      .data_i   (wr_frame_q),
      .pop_i    (pop),
      .data_o   (fifo_dout),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .level_o  (fifo_level)
   );

   assign pop         = bus.read_req & ~fifo_empty;
   assign overrun_set = wr_valid_q & fifo_full & ~pop;

   // Sticky flags: a new event in the clear cycle keeps the flag set
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         iq_overrun_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         iq_overrun_q <= overrun_set | (iq_overrun_q & ~bus.overrun_clr);
         sync_err_q   <= sync_set_d | (sync_err_q & ~bus.overrun_clr);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         out_q <= '0;
      end else if (pop) begin
         out_q <= iq_frame_t'(fifo_dout);
      end
   end

   assign bus.OUT_RX1_I  = out_q.rx1.i;
   assign bus.OUT_RX1_Q  = out_q.rx1.q;
   assign bus.OUT_RX2_I  = out_q.rx2.i;
   assign bus.OUT_RX2_Q  = out_q.rx2.q;
   assign bus.in_empty   = fifo_empty;
   assign bus.fill_level = fifo_level;
   assign bus.iq_overrun = iq_overrun_q;
   assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_rx_iq_scheduler.sv
// tb/tb_rx_iq_scheduler.sv - directed scoreboard bench for rx_iq_scheduler
module tb_rx_iq_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [95:0] sb[$];
   logic [95:0] last_out = '0;

   always #5 clk = ~clk;

   rx_iq_scheduler_if #(.FIFO_DEPTH(8)) bus_if ();

   rx_iq_scheduler #(.FIFO_DEPTH(8)) dut (
      .clk_in   (clk),
      .reset_in (rst),
      .bus      (bus_if)
   );

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [95:0] out_vec();
      return {bus_if.OUT_RX1_I, bus_if.OUT_RX1_Q, bus_if.OUT_RX2_I, bus_if.OUT_RX2_Q};
   endfunction

   function automatic logic [95:0] mkf(input int k);
      return {24'h100000 + 24'(k), 24'h200000 + 24'(k), 24'h300000 + 24'(k), 24'h400000 + 24'(k)};
   endfunction

   task automatic strobe(input bit v1, input logic [23:0] i1, input logic [23:0] q1,
                         input bit v2, input logic [23:0] i2, input logic [23:0] q2);
      bus_if.rx1_valid = v1;
      bus_if.RX1_I     = i1;
      bus_if.RX1_Q     = q1;
      bus_if.rx2_valid = v2;
      bus_if.RX2_I     = i2;
      bus_if.RX2_Q     = q2;
      tick();
      bus_if.rx1_valid = 1'b0;
      bus_if.rx2_valid = 1'b0;
   endtask

   task automatic send_pair(input int k);
      logic [95:0] f;
      f = mkf(k);
      strobe(1'b1, f[95:72], f[71:48], 1'b1, f[47:24], f[23:0]);
   endtask

   task automatic pop_check(input string tag);
      logic [95:0] exp;
      bus_if.read_req = 1'b1;
      tick();
      bus_if.read_req = 1'b0;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s: observed=pop expected=scoreboard entry", tag);
      end else begin
         exp = sb.pop_front();
         check(tag, out_vec(), exp);
         last_out = exp;
      end
   endtask

   task automatic clear_flags();
      bus_if.overrun_clr = 1'b1;
      tick();
      bus_if.overrun_clr = 1'b0;
   endtask

   initial begin
      bus_if.rx2_en      = 1'b0;
      bus_if.rx1_valid   = 1'b0;
      bus_if.rx2_valid   = 1'b0;
      bus_if.RX1_I       = '0;
      bus_if.RX1_Q       = '0;
      bus_if.RX2_I       = '0;
      bus_if.RX2_Q       = '0;
      bus_if.read_req    = 1'b0;
      bus_if.overrun_clr = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check("rst_empty",   96'(bus_if.in_empty),   96'd1);
      check("rst_fill",    96'(bus_if.fill_level), 96'd0);
      check("rst_overrun", 96'(bus_if.iq_overrun), 96'd0);
      check("rst_sync",    96'(bus_if.sync_err),   96'd0);
      check("rst_out",     out_vec(),              96'd0);

      // RX1-only mode; the RX2 strobe must be ignored and RX2 zero-filled
      sb.push_back({24'h123456, 24'hFEDCBA, 48'd0});
      strobe(1'b1, 24'h123456, 24'hFEDCBA, 1'b1, 24'h777777, 24'h555555);
      tick();
      check("rx1only_fill", 96'(bus_if.fill_level), 96'd1);
      pop_check("rx1only_frame");
      check("rx1only_empty", 96'(bus_if.in_empty), 96'd1);
      bus_if.read_req = 1'b1;
      tick();
      bus_if.read_req = 1'b0;
      check("empty_read_hold", out_vec(), last_out);
      check("empty_read_fill", 96'(bus_if.fill_level), 96'd0);

      // Paired mode, RX2 three cycles after RX1
      bus_if.rx2_en = 1'b1;
      tick();
      strobe(1'b1, 24'h0A0A0A, 24'h0B0B0B, 1'b0, 24'h0, 24'h0);
      tick();
      tick();
      check("pair_wait_fill", 96'(bus_if.fill_level), 96'd0);
      sb.push_back({24'h0A0A0A, 24'h0B0B0B, 24'h000001, 24'h800000});
      strobe(1'b0, 24'h0, 24'h0, 1'b1, 24'h000001, 24'h800000);
      check("pair_pipe_fill", 96'(bus_if.fill_level), 96'd0);
      tick();
      check("pair_fill", 96'(bus_if.fill_level), 96'd1);
      pop_check("pair_frame");

      // Double RX1 raises sync_err; frame uses the second RX1
      strobe(1'b1, 24'h111111, 24'h222222, 1'b0, 24'h0, 24'h0);
      strobe(1'b1, 24'h333333, 24'h444444, 1'b0, 24'h0, 24'h0);
      check("sync_set", 96'(bus_if.sync_err), 96'd1);
      sb.push_back({24'h333333, 24'h444444, 24'h555555, 24'h666666});
      strobe(1'b0, 24'h0, 24'h0, 1'b1, 24'h555555, 24'h666666);
      tick();
      pop_check("sync_frame");
      clear_flags();
      check("sync_clr", 96'(bus_if.sync_err), 96'd0);

      // Nine frames into an eight-deep FIFO
      for (int k = 0; k < 9; k++) begin
         if (k < 8) sb.push_back(mkf(k));
         send_pair(k);
      end
      tick();
      tick();
      check("full_fill",    96'(bus_if.fill_level), 96'd8);
      check("full_overrun", 96'(bus_if.iq_overrun), 96'd1);
      for (int k = 0; k < 8; k++) pop_check($sformatf("full_order%0d", k));
      check("drain_empty", 96'(bus_if.in_empty), 96'd1);
      clear_flags();
      check("overrun_clr", 96'(bus_if.iq_overrun), 96'd0);

      // Full FIFO, write and read on the same edge
      for (int k = 0; k < 8; k++) begin
         sb.push_back(mkf(16 + k));
         send_pair(16 + k);
      end
      tick();
      check("refill_fill", 96'(bus_if.fill_level), 96'd8);
      sb.push_back(mkf(40));
      send_pair(40);
      pop_check("simul_pop");
      check("simul_overrun", 96'(bus_if.iq_overrun), 96'd0);
      check("simul_fill",    96'(bus_if.fill_level), 96'd8);
      for (int k = 0; k < 8; k++) pop_check($sformatf("simul_order%0d", k));
      check("simul_empty", 96'(bus_if.in_empty), 96'd1);

      // Toggling rx2_en discards a held RX1 without a frame or error
      strobe(1'b1, 24'hDDDDDD, 24'hDDDDDD, 1'b0, 24'h0, 24'h0);
      bus_if.rx2_en = 1'b0;
      tick();
      bus_if.rx2_en = 1'b1;
      tick();
      tick();
      strobe(1'b0, 24'h0, 24'h0, 1'b1, 24'hABCDEF, 24'h012345);
      tick();
      check("toggle_nofr", 96'(bus_if.fill_level), 96'd0);
      sb.push_back({24'h765432, 24'h13579B, 24'hABCDEF, 24'h012345});
      strobe(1'b1, 24'h765432, 24'h13579B, 1'b0, 24'h0, 24'h0);
      tick();
      pop_check("rx2_first_frame");
      check("toggle_sync", 96'(bus_if.sync_err), 96'd0);

      // Reset while holding RX1 with three frames queued
      for (int k = 0; k < 3; k++) begin
         sb.push_back(mkf(60 + k));
         send_pair(60 + k);
      end
      strobe(1'b1, 24'hEEEEEE, 24'hEEEEEE, 1'b0, 24'h0, 24'h0);
      tick();
      pop_check("pre_reset_pop");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      check("mid_rst_empty", 96'(bus_if.in_empty),   96'd1);
      check("mid_rst_fill",  96'(bus_if.fill_level), 96'd0);
      check("mid_rst_out",   out_vec(),              96'd0);
      strobe(1'b0, 24'h0, 24'h0, 1'b1, 24'h999999, 24'h888888);
      tick();
      check("post_rst_nofr",  96'(bus_if.fill_level), 96'd0);
      check("post_rst_empty", 96'(bus_if.in_empty),   96'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
